// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer for the Mini-SRC ALU and its Y/Z/HI/LO
// registers. Accepts one R-format request and steps the datapath strobes
// through load-A, execute, and write-back. All outputs are registered and
// decoded from the next state, so they line up with the state register.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; all strobes low
// LDA   | ra onto the bus, load Y
// EXEC  | rb onto the bus, ALU opcode driven; Z loads on the last cycle
// WLO   | Z_LO onto the bus; write rc, or LO for mul/div
// WHI   | Z_HI onto the bus, load HI (mul/div only)
// FIN   | one-cycle done pulse; illegal flagged for undefined opcodes
module alu_seq_ctrl #(
  parameter int WAIT_MULDIV = 2
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic       start,
  input  logic [4:0] opcode,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  input  logic [3:0] rc,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic [3:0] rf_rd_sel,
  output logic       rf_out,
  output logic       y_in,
  output logic [4:0] alu_opcode,
  output logic       incpc,
  output logic       z_in,
  output logic       z_lo_out,
  output logic       z_hi_out,
  output logic       rf_in,
  output logic [3:0] rf_wr_sel,
  output logic       lo_in,
  output logic       hi_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_LDA, S_EXEC, S_WLO, S_WHI, S_FIN
  } state_t;

  localparam logic [2:0] WAIT_CNT = 3'(WAIT_MULDIV);

  state_t     state, state_d;
  logic [2:0] cnt, cnt_d;
  logic [4:0] op_q, op_d;
  logic [3:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic       ill_q, ill_d;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == 5'b01111) || (op == 5'b10000);
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == 5'b10001) || (op == 5'b10010);
  endfunction

  function automatic logic is_binary(input logic [4:0] op);
    return ((op >= 5'b00011) && (op <= 5'b01011)) || is_muldiv(op);
  endfunction

  // IncPC is never used by this sequencer.
  assign incpc = 1'b0;

  // Next-state, counter and request-latch logic.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    ill_d   = ill_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          op_d  = opcode;
          ra_d  = ra;
          rb_d  = rb;
          rc_d  = rc;
          ill_d = 1'b0;
          cnt_d = 3'd0;
          if (is_binary(opcode)) begin
            state_d = S_LDA;
          end else if (is_unary(opcode)) begin
            state_d = S_EXEC;
          end else begin
            state_d = S_FIN;
            ill_d   = 1'b1;
          end
        end
      end
      S_LDA: begin
        state_d = S_EXEC;
        cnt_d   = is_muldiv(op_q) ? WAIT_CNT : 3'd0;
      end
      S_EXEC: begin
        if (cnt == 3'd0) state_d = S_WLO;
        else             cnt_d   = cnt - 3'd1;
      end
      S_WLO:   state_d = is_muldiv(op_q) ? S_WHI : S_FIN;
      S_WHI:   state_d = S_FIN;
      S_FIN: begin
        state_d = S_IDLE;
        ill_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus outputs decoded from the next state.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      op_q       <= 5'd0;
      ra_q       <= 4'd0;
      rb_q       <= 4'd0;
      rc_q       <= 4'd0;
      ill_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      rf_rd_sel  <= 4'd0;
      rf_out     <= 1'b0;
      y_in       <= 1'b0;
      alu_opcode <= 5'd0;
      z_in       <= 1'b0;
      z_lo_out   <= 1'b0;
      z_hi_out   <= 1'b0;
      rf_in      <= 1'b0;
      rf_wr_sel  <= 4'd0;
      lo_in      <= 1'b0;
      hi_in      <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      op_q       <= op_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      rc_q       <= rc_d;
      ill_q      <= ill_d;
      busy       <= (state_d != S_IDLE);
      done       <= (state_d == S_FIN);
      illegal    <= (state_d == S_FIN) && ill_d;
      rf_rd_sel  <= (state_d == S_LDA)  ? ra_d :
                    (state_d == S_EXEC) ? rb_d : 4'd0;
      rf_out     <= (state_d == S_LDA) || (state_d == S_EXEC);
      y_in       <= (state_d == S_LDA);
      alu_opcode <= (state_d == S_EXEC) ? op_d : 5'd0;
      z_in       <= (state_d == S_EXEC) && (cnt_d == 3'd0);
      z_lo_out   <= (state_d == S_WLO);
      z_hi_out   <= (state_d == S_WHI);
      rf_in      <= (state_d == S_WLO) && !is_muldiv(op_d);
      rf_wr_sel  <= ((state_d == S_WLO) && !is_muldiv(op_d)) ? rc_d : 4'd0;
      lo_in      <= (state_d == S_WLO) && is_muldiv(op_d);
      hi_in      <= (state_d == S_WHI);
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl: per-cycle strobe expectations derived from the
// cycle timeline of each operation class, plus a small datapath model driven
// by the DUT strobes whose results are compared with plain arithmetic.
module tb_alu_seq_ctrl;

  localparam int W = 2;

  logic       clock = 1'b0;
  logic       clear_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic [3:0] ra = 4'd0, rb = 4'd0, rc = 4'd0;
  logic       busy, done, illegal, rf_out, y_in, incpc, z_in;
  logic       z_lo_out, z_hi_out, rf_in, lo_in, hi_in;
  logic [3:0] rf_rd_sel, rf_wr_sel;
  logic [4:0] alu_opcode;

  int n_cmp = 0;
  int n_mis = 0;

  alu_seq_ctrl #(.WAIT_MULDIV(W)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .opcode(opcode),
    .ra(ra), .rb(rb), .rc(rc), .busy(busy), .done(done), .illegal(illegal),
    .rf_rd_sel(rf_rd_sel), .rf_out(rf_out), .y_in(y_in),
    .alu_opcode(alu_opcode), .incpc(incpc), .z_in(z_in),
    .z_lo_out(z_lo_out), .z_hi_out(z_hi_out), .rf_in(rf_in),
    .rf_wr_sel(rf_wr_sel), .lo_in(lo_in), .hi_in(hi_in)
  );

  always #5 clock = ~clock;

  logic [24:0] ovec;
  assign ovec = {busy, done, illegal, rf_rd_sel, rf_out, y_in, alu_opcode,
                 incpc, z_in, z_lo_out, z_hi_out, rf_in, rf_wr_sel,
                 lo_in, hi_in};

  // Reference ALU: plain arithmetic, returns {HI, LO}.
  function automatic logic [63:0] alu_fn(input logic [4:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] sa, sb;
    int s;
    s  = int'(b[4:0]);
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      5'd3:  return {32'd0, a + b};
      5'd4:  return {32'd0, a - b};
      5'd5:  return {32'd0, a >> s};
      5'd6:  return {32'd0, 32'($signed(a) >>> s)};
      5'd7:  return {32'd0, a << s};
      5'd8:  return {32'd0, (a >> s) | (a << (32 - s))};
      5'd9:  return {32'd0, (a << s) | (a >> (32 - s))};
      5'd10: return {32'd0, a & b};
      5'd11: return {32'd0, a | b};
      5'd15: return 64'($signed(sa) * $signed(sb));
      5'd16: return (b == 32'd0) ? 64'd0 :
                    {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      5'd17: return {32'd0, 32'd0 - b};
      5'd18: return {32'd0, ~b};
      default: return 64'd0;
    endcase
  endfunction

  // Datapath model: registers, Y, Z, HI, LO updated from DUT strobes.
  logic [31:0] R [16];
  logic [31:0] pre_vals [16];
  logic [31:0] Y = 0, ZH = 0, ZL = 0, HI = 0, LO = 0;
  logic [31:0] bus;
  logic        pre_all = 1'b0;
  logic        lohi_seen = 1'b0;

  always_comb bus = rf_out ? R[rf_rd_sel] : z_lo_out ? ZL : z_hi_out ? ZH : 32'd0;

  // Model register updates on each rising edge.
  always @(posedge clock) begin
    if (pre_all) begin
      R <= pre_vals;
      lohi_seen <= 1'b0;
    end
    if (y_in) Y <= bus;
    if (z_in) {ZH, ZL} <= alu_fn(alu_opcode, Y, bus);
    if (rf_in) R[rf_wr_sel] <= bus;
    if (lo_in) LO <= bus;
    if (hi_in) HI <= bus;
    if (lo_in || hi_in) lohi_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_pre();
    for (int i = 0; i < 16; i++) pre_vals[i] = $urandom;
  endtask

  task automatic commit_pre();
    start = 1'b0;
    pre_all = 1'b1;
    @(posedge clock);
    #1 pre_all = 1'b0;
  endtask

  // Run one request from IDLE; called at a point well before a rising edge.
  task automatic run_op(input logic [4:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] c,
                        input int pulse_c, input bit hold);
    bit md, un, bin, ill;
    int w, es, ee, wlo, whi, dc;
    logic [63:0] res;
    logic [31:0] prev_rc;
    logic [24:0] ev;
    logic e_rdr, e_rfin;
    logic [3:0] e_sel;
    md  = (op == 5'd15) || (op == 5'd16);
    un  = (op == 5'd17) || (op == 5'd18);
    bin = ((op >= 5'd3) && (op <= 5'd11)) || md;
    ill = !bin && !un;
    w   = md ? W : 0;
    if (ill) begin
      es = -1; ee = -1; wlo = -1; whi = -1; dc = 1;
    end else begin
      es  = un ? 1 : 2;
      ee  = es + w;
      wlo = ee + 1;
      whi = md ? wlo + 1 : -1;
      dc  = (md ? whi : wlo) + 1;
    end
    res     = alu_fn(op, R[a], R[b]);
    prev_rc = R[c];
    opcode = op; ra = a; rb = b; rc = c; start = 1'b1;
    @(posedge clock);
    #1 if (!hold) start = 1'b0;
    for (int cy = 1; cy <= dc; cy++) begin
      @(negedge clock);
      if (cy == pulse_c) begin
        start = 1'b1;
        opcode = 5'($urandom); ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
      end else if (!hold) begin
        start = 1'b0;
      end
      e_rdr  = (bin && cy == 1) || (cy >= es && cy <= ee);
      e_sel  = (bin && cy == 1) ? a : (cy >= es && cy <= ee) ? b : 4'd0;
      e_rfin = (cy == wlo) && !md;
      ev = {1'b1, cy == dc, ill && cy == dc, e_sel, e_rdr, bin && cy == 1,
            (cy >= es && cy <= ee) ? op : 5'd0, 1'b0, cy == ee, cy == wlo,
            cy == whi, e_rfin, e_rfin ? c : 4'd0, (cy == wlo) && md, cy == whi};
      check($sformatf("op%0d_cycle%0d", op, cy), 64'(ovec), 64'(ev));
    end
    @(negedge clock);
    if (!hold) start = 1'b0;
    check($sformatf("op%0d_idle_after", op), 64'(ovec), 64'd0);
    if (md) begin
      check($sformatf("op%0d_lo", op), 64'(LO), 64'(res[31:0]));
      check($sformatf("op%0d_hi", op), 64'(HI), 64'(res[63:32]));
    end else if (ill) begin
      check($sformatf("op%0d_rc_untouched", op), 64'(R[c]), 64'(prev_rc));
    end else begin
      check($sformatf("op%0d_rc", op), 64'(R[c]), 64'(res[31:0]));
    end
  endtask

  initial begin
    logic [4:0] legal [13];
    logic [4:0] rop;
    legal = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
              5'd15, 5'd16, 5'd17, 5'd18};

    // Reset state.
    for (int i = 0; i < 16; i++) R[i] = 32'd0;
    repeat (3) @(negedge clock);
    check("reset_outputs", 64'(ovec), 64'd0);
    clear_n = 1'b1;
    @(negedge clock);
    check("post_reset_idle", 64'(ovec), 64'd0);

    // Add R2=7 + R3=9 -> R5.
    randomize_pre(); pre_vals[2] = 32'd7; pre_vals[3] = 32'd9;
    commit_pre();
    run_op(5'b00011, 4'd2, 4'd3, 4'd5, 0, 1'b0);
    check("add_r5_16", 64'(R[5]), 64'd16);

    // Mul 0x10000 * 0x10000.
    randomize_pre(); pre_vals[1] = 32'h0001_0000; pre_vals[2] = 32'h0001_0000;
    commit_pre();
    run_op(5'b01111, 4'd1, 4'd2, 4'd7, 0, 1'b0);
    check("mul_lo_0", 64'(LO), 64'd0);
    check("mul_hi_1", 64'(HI), 64'd1);

    // Neg R4=5 -> R6.
    randomize_pre(); pre_vals[4] = 32'd5;
    commit_pre();
    run_op(5'b10001, 4'd9, 4'd4, 4'd6, 0, 1'b0);
    check("neg_r6", 64'(R[6]), 64'hFFFF_FFFB);

    // Undefined opcode.
    run_op(5'b00001, 4'd1, 4'd2, 4'd3, 0, 1'b0);

    // Start pulsed mid-operation must be ignored.
    randomize_pre(); commit_pre();
    run_op(5'b00011, 4'd1, 4'd2, 4'd8, 2, 1'b0);

    // Back-to-back subs with start held high.
    randomize_pre(); commit_pre();
    run_op(5'b00100, 4'd1, 4'd2, 4'd3, 0, 1'b1);
    run_op(5'b00100, 4'd3, 4'd4, 4'd10, 0, 1'b1);
    start = 1'b0;
    @(negedge clock);

    // Reset mid-EXEC of a mul.
    randomize_pre(); commit_pre();
    opcode = 5'b01111; ra = 4'd1; rb = 4'd2; rc = 4'd3; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_exec_busy", 64'(busy), 64'd1);
    clear_n = 1'b0;
    #1 check("reset_mid_op_outputs", 64'(ovec), 64'd0);
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
    check("after_reset_idle", 64'(ovec), 64'd0);
    check("no_lohi_after_reset", 64'(lohi_seen), 64'd0);

    // Randomized operations, including undefined opcodes and ignored starts.
    for (int k = 0; k < 40; k++) begin
      randomize_pre(); commit_pre();
      if ($urandom_range(0, 5) == 0) rop = 5'($urandom);
      else rop = legal[$urandom_range(0, 12)];
      run_op(rop, 4'($urandom), 4'($urandom), 4'($urandom),
             int'($urandom_range(0, 6)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
